// File: rtl/bus_arb.sv
// CPU/DMA memory bus arbiter: the CPU owns the bus by default; DMA steals bounded bursts
// while RDY pauses the CPU, followed by one cycle that re-issues the paused CPU read.
module bus_arb #(
    parameter int MAX_BURST = 8,
    parameter int MIN_CPU   = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] cpu_AD,
    input  logic [7:0]  cpu_DO,
    input  logic        cpu_WE,
    output logic        RDY,
    input  logic        dma_req,
    input  logic [15:0] dma_AD,
    input  logic [7:0]  dma_DO,
    input  logic        dma_WE,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [7:0]  dma_DI,
    output logic [15:0] AD,
    output logic [7:0]  DO,
    output logic        WE,
    input  logic [7:0]  DI
);
    typedef enum logic [1:0] {
        S_CPU    = 2'd0,
        S_DMA    = 2'd1,
        S_RESUME = 2'd2
    } state_t;

    localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);
    localparam logic [7:0] C_MIN_CPU   = 8'(MIN_CPU);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_beat;
    logic [7:0] w_beat_next;
    logic [7:0] r_holdoff;
    logic [7:0] w_holdoff_next;
    logic       r_rvalid;
    logic       w_rd_beat;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state   <= S_CPU;
            r_beat    <= 8'd0;
            r_holdoff <= 8'd0;
            r_rvalid  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_beat    <= w_beat_next;
            r_holdoff <= w_holdoff_next;
            r_rvalid  <= w_rd_beat;
        end
    end

    // Read data for a DMA read beat arrives one cycle later, hence the registered valid.
    assign w_rd_beat  = (r_state == S_DMA) && dma_req && !dma_WE;
    assign dma_rvalid = r_rvalid;
    assign dma_DI     = DI;

    always_comb begin
        AD             = cpu_AD;
        DO             = cpu_DO;
        WE             = cpu_WE;
        RDY            = 1'b1;
        dma_gnt        = 1'b0;
        w_state_next   = r_state;
        w_beat_next    = r_beat;
        w_holdoff_next = r_holdoff;
        case (r_state)
            S_CPU: begin
                if (r_holdoff != 8'd0) begin
                    w_holdoff_next = r_holdoff - 8'd1;
                end
                // Never pause the CPU in a write cycle, or the write would be lost.
                if (dma_req && !cpu_WE && (r_holdoff == 8'd0)) begin
                    w_state_next = S_DMA;
                    w_beat_next  = 8'd0;
                end
            end
            S_DMA: begin
                AD      = dma_AD;
                DO      = dma_DO;
                WE      = dma_WE & dma_req;
                RDY     = 1'b0;
                dma_gnt = 1'b1;
                if (dma_req) begin
                    w_beat_next = r_beat + 8'd1;
                    if ((r_beat + 8'd1) == C_MAX_BURST) begin
                        w_state_next = S_RESUME;
                    end
                end else begin
                    w_state_next = S_RESUME;
                end
            end
            S_RESUME: begin
                // Re-issue the paused CPU read so DI is valid when RDY returns high.
                WE             = 1'b0;
                RDY            = 1'b0;
                w_state_next   = S_CPU;
                w_holdoff_next = C_MIN_CPU;
            end
            default: begin
                w_state_next = S_CPU;
            end
        endcase
    end
endmodule
